// File: rtl/slew_ctrl_mc.sv
// Multi-channel slew controller: one shared datapath steps each channel's cvr toward target, one channel per clk.
// Channel k updates on the (k+1)-th edge after the tick-sampling edge; done pulses after edge CH; ticks during a scan flag overrun.
module slew_ctrl_mc #(
    parameter int CH = 4,
    parameter int GW = 8,
    parameter int OW = 8,
    parameter int SW = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             tick,
    input  logic [CH*GW-1:0] current,
    input  logic [CH*GW-1:0] target,
    input  logic [SW-1:0]    step,
    input  logic [GW-1:0]    deadband,
    input  logic [OW-1:0]    cvr_min,
    input  logic [OW-1:0]    cvr_max,
    output logic [CH*OW-1:0] cvr,
    output logic [CH-1:0]    at_limit,
    output logic [CH-1:0]    locked,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic             cfg_err
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {S_DISABLED, S_INIT, S_IDLE, S_SCAN} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_idx;
    logic [CH*OW-1:0]   r_cvr;
    logic [CH-1:0]      r_at_limit;
    logic [CH-1:0]      r_locked;
    logic               r_done;
    logic               r_overrun;

    logic [GW-1:0]      w_cur;
    logic [GW-1:0]      w_tgt;
    logic signed [GW:0] w_err;
    logic signed [GW:0] w_db;
    logic               w_up;
    logic               w_dn;
    logic [OW-1:0]      w_old;
    logic [OW-1:0]      w_clamp;
    logic [OW:0]        w_step;
    logic [OW:0]        w_sum;
    logic signed [OW:0] w_diff;
    logic [OW-1:0]      w_new;
    logic               w_lim;
    logic               w_cfg_err;

    assign w_cfg_err = (cvr_min > cvr_max);

    // Shared per-channel datapath, driven by the scan index
    always_comb begin
        w_cur   = current[r_idx*GW +: GW];
        w_tgt   = target[r_idx*GW +: GW];
        w_err   = $signed({1'b0, w_tgt}) - $signed({1'b0, w_cur});
        w_db    = $signed({1'b0, deadband});
        w_up    = (w_err > w_db);
        w_dn    = (w_err < -w_db);
        w_old   = r_cvr[r_idx*OW +: OW];
        w_clamp = w_old;
        if (w_old < cvr_min) begin
            w_clamp = cvr_min;
        end else if (w_old > cvr_max) begin
            w_clamp = cvr_max;
        end
        w_step  = {{(OW+1-SW){1'b0}}, step};
        w_sum   = {1'b0, w_clamp} + w_step;
        w_diff  = $signed({1'b0, w_clamp}) - $signed(w_step);
        w_new   = w_clamp;
        if (w_up) begin
            w_new = (w_sum > {1'b0, cvr_max}) ? cvr_max : w_sum[OW-1:0];
        end else if (w_dn) begin
            w_new = (w_diff < $signed({1'b0, cvr_min})) ? cvr_min : w_diff[OW-1:0];
        end
        w_lim   = (w_new == cvr_min) || (w_new == cvr_max);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_DISABLED;
            r_idx      <= '0;
            r_cvr      <= '0;
            r_at_limit <= '0;
            r_locked   <= '0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            if (!en) begin
                // Abort anything in flight; cvr and flags keep their values
                r_state <= S_DISABLED;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    S_DISABLED: r_state <= S_INIT;
                    S_INIT: begin
                        if (!w_cfg_err) begin
                            r_cvr      <= {CH{cvr_min}};
                            r_at_limit <= '1;
                        end
                        r_locked <= '0;
                        r_state  <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (tick) begin
                            r_state <= S_SCAN;
                            r_idx   <= '0;
                        end
                    end
                    S_SCAN: begin
                        if (tick) begin
                            r_overrun <= 1'b1;
                        end
                        if (!w_cfg_err) begin
                            r_cvr[r_idx*OW +: OW] <= w_new;
                            r_at_limit[r_idx]     <= w_lim;
                            r_locked[r_idx]       <= !w_up && !w_dn;
                        end
                        if (r_idx == IW'(CH-1)) begin
                            r_state <= S_IDLE;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    default: r_state <= S_DISABLED;
                endcase
            end
        end
    end

    assign cvr      = r_cvr;
    assign at_limit = r_at_limit;
    assign locked   = r_locked;
    assign busy     = (r_state == S_SCAN);
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign cfg_err  = w_cfg_err;

endmodule
